// File: rtl/jtag_pkg.sv
// Shared constants and types for the JTAG instruction/data register bank.
package jtag_pkg;

  // Default geometry and identification.
  localparam int          DEFAULT_IR_WIDTH  = 4;
  localparam int          DEFAULT_DR_WIDTH  = 32;
  localparam logic [31:0] DEFAULT_IDCODE    = 32'h1000_0001;

  // Default instruction opcodes; anything not listed selects BYPASS.
  localparam logic [3:0]  DEFAULT_OP_IDCODE = 4'h1;
  localparam logic [3:0]  DEFAULT_OP_USER   = 4'h2;
  localparam logic [3:0]  DEFAULT_OP_BYPASS = 4'hF;

  // Fixed pattern loaded into the IR on Capture-IR (two LSBs).
  localparam logic [1:0]  IR_CAPTURE        = 2'b01;

  // Which data register sits between TDI and TDO.
  typedef enum logic [1:0] {
    SEL_BYPASS,
    SEL_IDCODE,
    SEL_USER
  } dr_sel_e;

  // One-hot view of the TAP strobe that actually acts this edge.
  typedef struct packed {
    logic ir_capture;
    logic ir_shift;
    logic ir_update;
    logic dr_capture;
    logic dr_shift;
    logic dr_update;
  } tap_action_t;

endpackage

// File: rtl/jtag_shift_reg.sv
// Generic LSB-first shift register with parallel capture and a clear.
// Priority: reset > clear > capture > shift; otherwise hold.
module jtag_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             tck,
  input  logic             reset,
  input  logic             clear,
  input  logic             capture_en,
  input  logic [WIDTH-1:0] capture_data,
  input  logic             shift_en,
  input  logic             tdi,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  // Next-value selection: new TDI bit enters at the MSB, LSB falls out.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    data_d = data_q;
    if (clear) begin
      data_d = '0;
    end else if (capture_en) begin
      data_d = capture_data;
    end else if (shift_en) begin
      data_d = {tdi, data_q[WIDTH-1:1]};
    end
  end

  // Shift register state.
  always_ff @(posedge tck or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignment so all flops sample the same pre-edge values.
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data = data_q;

endmodule

// File: rtl/jtag_shift_regs.sv
// JTAG instruction and data register bank: IR, BYPASS, IDCODE and a USER
// register exposed to fabric with capture/update strobes. Consumes the
// decoded TAP state strobes and drives TDO.
module jtag_shift_regs
  import jtag_pkg::*;
#(
  parameter int                   IR_WIDTH     = DEFAULT_IR_WIDTH,
  parameter int                   DR_WIDTH     = DEFAULT_DR_WIDTH,
  parameter logic [DR_WIDTH-1:0]  IDCODE_VALUE = DEFAULT_IDCODE,
  parameter logic [IR_WIDTH-1:0]  OP_IDCODE    = DEFAULT_OP_IDCODE,
  parameter logic [IR_WIDTH-1:0]  OP_USER      = DEFAULT_OP_USER,
  parameter logic [IR_WIDTH-1:0]  OP_BYPASS    = DEFAULT_OP_BYPASS
) (
  input  logic                tck,
  input  logic                reset,
  input  logic                tdi,
  input  logic                test_logic_reset,
  input  logic                capture_dr,
  input  logic                shift_dr,
  input  logic                update_dr,
  input  logic                capture_ir,
  input  logic                shift_ir,
  input  logic                update_ir,
  output logic                tdo,
  output logic                tdo_en,
  output logic [IR_WIDTH-1:0] ir_value,
  input  logic [DR_WIDTH-1:0] user_capture_data,
  output logic                user_capture_strobe,
  output logic [DR_WIDTH-1:0] user_update_data,
  output logic                user_update_valid
);

  localparam logic [IR_WIDTH-1:0] IR_CAPTURE_WORD =
    {{(IR_WIDTH-2){1'b0}}, IR_CAPTURE};

  tap_action_t         act;
  dr_sel_e             dr_sel;

  logic [IR_WIDTH-1:0] ir_shift_q;
  logic [IR_WIDTH-1:0] ir_value_d;
  logic [IR_WIDTH-1:0] ir_value_q;

  logic [DR_WIDTH-1:0] dr_shift_q;
  logic [DR_WIDTH-1:0] dr_capture_word;
  logic                dr_capture_en;
  logic                dr_shift_en;

  logic                bypass_d;
  logic                bypass_q;

  logic [DR_WIDTH-1:0] user_update_data_d;
  logic [DR_WIDTH-1:0] user_update_data_q;
  logic                user_capture_strobe_d;
  logic                user_capture_strobe_q;
  logic                user_update_valid_d;
  logic                user_update_valid_q;

  logic                tdo_mux;

  // Strobe priority: test_logic_reset suppresses everything, then the first
  // high strobe in IR-capture..DR-update order is the only one that acts.
  always_comb begin
    act = '0;
    if (!test_logic_reset) begin
      if (capture_ir) begin
        act.ir_capture = 1'b1;
      end else if (shift_ir) begin
        act.ir_shift = 1'b1;
      end else if (update_ir) begin
        act.ir_update = 1'b1;
      end else if (capture_dr) begin
        act.dr_capture = 1'b1;
      end else if (shift_dr) begin
        act.dr_shift = 1'b1;
      end else if (update_dr) begin
        act.dr_update = 1'b1;
      end
    end
  end

  // Data register selection from the latched instruction only, so a DR scan
  // always sees the opcode from the last Update-IR.
  always_comb begin
    dr_sel = SEL_BYPASS;
    if (ir_value_q == OP_IDCODE) begin
      dr_sel = SEL_IDCODE;
    end else if (ir_value_q == OP_USER) begin
      dr_sel = SEL_USER;
    end else if (ir_value_q == OP_BYPASS) begin
      dr_sel = SEL_BYPASS;
    end
  end

  // Instruction shift chain; test_logic_reset clears it.
  jtag_shift_reg #(
    .WIDTH(IR_WIDTH)
  ) u_ir_shift (
    .tck          (tck),
    .reset        (reset),
    .clear        (test_logic_reset),
    .capture_en   (act.ir_capture),
    .capture_data (IR_CAPTURE_WORD),
    .shift_en     (act.ir_shift),
    .tdi          (tdi),
    .data         (ir_shift_q)
  );

  // IDCODE and USER share one DR shift chain; BYPASS has its own bit.
  always_comb begin
    dr_capture_word = (dr_sel == SEL_IDCODE) ? IDCODE_VALUE : user_capture_data;
    dr_capture_en   = act.dr_capture && (dr_sel != SEL_BYPASS);
    dr_shift_en     = act.dr_shift   && (dr_sel != SEL_BYPASS);
  end

  jtag_shift_reg #(
    .WIDTH(DR_WIDTH)
  ) u_dr_shift (
    .tck          (tck),
    .reset        (reset),
    .clear        (1'b0),
    .capture_en   (dr_capture_en),
    .capture_data (dr_capture_word),
    .shift_en     (dr_shift_en),
    .tdi          (tdi),
    .data         (dr_shift_q)
  );

  // Next-state for the instruction latch, bypass bit, USER update word and strobes.
  always_comb begin
    ir_value_d            = ir_value_q;
    bypass_d              = bypass_q;
    user_update_data_d    = user_update_data_q;
    user_capture_strobe_d = 1'b0;
    user_update_valid_d   = 1'b0;

    if (test_logic_reset) begin
      ir_value_d = OP_IDCODE;
      bypass_d   = 1'b0;
    end else begin
      if (act.ir_update) begin
        ir_value_d = ir_shift_q;
      end

      if (act.dr_capture) begin
        if (dr_sel == SEL_BYPASS) begin
          bypass_d = 1'b0;
        end
        if (dr_sel == SEL_USER) begin
          user_capture_strobe_d = 1'b1;
        end
      end

      if (act.dr_shift && (dr_sel == SEL_BYPASS)) begin
        bypass_d = tdi;
      end

      if (act.dr_update && (dr_sel == SEL_USER)) begin
        user_update_data_d  = dr_shift_q;
        user_update_valid_d = 1'b1;
      end
    end
  end

  // Registered instruction, bypass bit, USER update word and one-cycle strobes.
  always_ff @(posedge tck or posedge reset) begin
    if (reset) begin
      ir_value_q            <= OP_IDCODE;
      bypass_q              <= 1'b0;
      user_update_data_q    <= '0;
      user_capture_strobe_q <= 1'b0;
      user_update_valid_q   <= 1'b0;
    end else begin
      ir_value_q            <= ir_value_d;
      bypass_q              <= bypass_d;
      user_update_data_q    <= user_update_data_d;
      user_capture_strobe_q <= user_capture_strobe_d;
      user_update_valid_q   <= user_update_valid_d;
    end
  end

  // TDO mux from registered state only; forced quiet while reset is held.
  always_comb begin
    tdo_mux = 1'b0;
    if (!reset) begin
      if (shift_ir) begin
        tdo_mux = ir_shift_q[0];
      end else if (shift_dr) begin
        tdo_mux = (dr_sel == SEL_BYPASS) ? bypass_q : dr_shift_q[0];
      end
    end
  end

  assign tdo                 = tdo_mux;
  assign tdo_en              = !reset && (shift_dr || shift_ir);
  assign ir_value            = ir_value_q;
  assign user_update_data    = user_update_data_q;
  assign user_capture_strobe = user_capture_strobe_q;
  assign user_update_valid   = user_update_valid_q;

endmodule

// File: tb/tb_jtag_shift_regs.sv
// Self-checking bench for jtag_shift_regs: directed scenarios plus randomized
// IR/DR scans checked against a chain-level model of the register bank.
module tb_jtag_shift_regs;

  localparam logic [31:0] IDCODE = 32'h1000_0001;

  // Strobe vector bit positions: {tlr, cir, sir, uir, cdr, sdr, udr}.
  localparam logic [6:0] S_NONE = 7'b0000000;
  localparam logic [6:0] S_TLR  = 7'b1000000;
  localparam logic [6:0] S_CIR  = 7'b0100000;
  localparam logic [6:0] S_SIR  = 7'b0010000;
  localparam logic [6:0] S_UIR  = 7'b0001000;
  localparam logic [6:0] S_CDR  = 7'b0000100;
  localparam logic [6:0] S_SDR  = 7'b0000010;
  localparam logic [6:0] S_UDR  = 7'b0000001;

  logic        tck = 1'b0;
  logic        reset;
  logic        tdi;
  logic [6:0]  strb;
  logic        tdo;
  logic        tdo_en;
  logic [3:0]  ir_value;
  logic [31:0] user_capture_data;
  logic        user_capture_strobe;
  logic [31:0] user_update_data;
  logic        user_update_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Observations taken mid-cycle by cycle().
  logic obs_tdo, obs_en, obs_cs, obs_uv;

  // Reference state.
  logic [3:0]  ir_m;
  logic [31:0] upd_m;

  always #5 tck = ~tck;

  jtag_shift_regs dut (
    .tck                 (tck),
    .reset               (reset),
    .tdi                 (tdi),
    .test_logic_reset    (strb[6]),
    .capture_dr          (strb[2]),
    .shift_dr            (strb[1]),
    .update_dr           (strb[0]),
    .capture_ir          (strb[5]),
    .shift_ir            (strb[4]),
    .update_ir           (strb[3]),
    .tdo                 (tdo),
    .tdo_en              (tdo_en),
    .ir_value            (ir_value),
    .user_capture_data   (user_capture_data),
    .user_capture_strobe (user_capture_strobe),
    .user_update_data    (user_update_data),
    .user_update_valid   (user_update_valid)
  );

  // ---------------- reference model ----------------
  // 0 = bypass, 1 = idcode, 2 = user
  function automatic int sel_of(input logic [3:0] op);
    if (op == 4'h1) return 1;
    if (op == 4'h2) return 2;
    return 0;
  endfunction

  // The bit stream seen at TDO is the captured register contents (LSB first)
  // followed by the TDI bits; the register finally holds the window after n shifts.
  function automatic logic [95:0] model_chain(input logic [3:0] op, input logic [31:0] cap,
                                              input logic [63:0] din);
    case (sel_of(op))
      1:       return {din, IDCODE};
      2:       return {din, cap};
      default: return {31'd0, din, 1'b0};
    endcase
  endfunction

  function automatic logic [31:0] model_final(input logic [95:0] chain, input int n);
    logic [95:0] s;
    s = chain >> n;
    return s[31:0];
  endfunction

  function automatic logic [63:0] mask_of(input int n);
    if (n >= 64) return '1;
    return (64'd1 << n) - 64'd1;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic cycle(input logic [6:0] s, input logic t);
    @(negedge tck);
    strb = s;
    tdi  = t;
    #1;
    obs_tdo = tdo;
    obs_en  = tdo_en;
    obs_cs  = user_capture_strobe;
    obs_uv  = user_update_valid;
  endtask

  task automatic ir_scan(input logic [3:0] op, output logic [3:0] cap_bits);
    cycle(S_CIR, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(S_SIR, op[i]);
      cap_bits[i] = obs_tdo;
    end
    cycle(S_NONE, 1'b0);
    cycle(S_UIR, 1'b0);
    cycle(S_NONE, 1'b0);
    ir_m = op;
  endtask

  task automatic dr_scan(input int n, input logic [63:0] din, output logic [63:0] dout,
                         output int cs_cnt, output int uv_cnt, output logic cs_first,
                         output logic uv_after, output logic en_all);
    dout = '0; cs_cnt = 0; uv_cnt = 0; en_all = 1'b1; cs_first = 1'b0;
    cycle(S_CDR, 1'b0);
    cs_cnt += int'(obs_cs); uv_cnt += int'(obs_uv);
    for (int i = 0; i < n; i++) begin
      cycle(S_SDR, din[i]);
      dout[i] = obs_tdo;
      en_all &= obs_en;
      if (i == 0) cs_first = obs_cs;
      cs_cnt += int'(obs_cs); uv_cnt += int'(obs_uv);
    end
    cycle(S_NONE, 1'b0);
    cs_cnt += int'(obs_cs); uv_cnt += int'(obs_uv);
    cycle(S_UDR, 1'b0);
    cs_cnt += int'(obs_cs); uv_cnt += int'(obs_uv);
    cycle(S_NONE, 1'b0);
    uv_after = obs_uv;
    cs_cnt += int'(obs_cs); uv_cnt += int'(obs_uv);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [63:0] dout, din;
    int cs_cnt, uv_cnt;
    logic cs_first, uv_after, en_all;
    logic [95:0] chain;
    reset = 1'b1; strb = S_SDR; tdi = 1'b1;
    repeat (2) @(negedge tck);
    #1;
    n_checks++;
    if ({tdo, tdo_en, user_capture_strobe, user_update_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got tdo/en/cs/uv=%b required 0000",
               {tdo, tdo_en, user_capture_strobe, user_update_valid});
    end
    n_checks++;
    if (ir_value !== 4'h1 || user_update_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_regs: got ir=%h upd=%h required ir=1 upd=0", ir_value, user_update_data);
    end
    @(negedge tck);
    strb = S_NONE; reset = 1'b0;
    ir_m = 4'h1; upd_m = 32'h0;

    din = {$urandom, $urandom};
    dr_scan(32, din, dout, cs_cnt, uv_cnt, cs_first, uv_after, en_all);
    chain = model_chain(ir_m, user_capture_data, din);
    n_checks++;
    if (dout[31:0] !== IDCODE || dout[31:0] !== chain[31:0]) begin
      n_fail++;
      $display("FAIL idcode_stream: got %h required %h", dout[31:0], IDCODE);
    end
    n_checks++;
    if (en_all !== 1'b1 || cs_cnt != 0 || uv_cnt != 0 || user_update_data !== upd_m) begin
      n_fail++;
      $display("FAIL idcode_side: en=%b cs=%0d uv=%0d upd=%h required en=1 cs=0 uv=0 upd=%h",
               en_all, cs_cnt, uv_cnt, user_update_data, upd_m);
    end
  endtask

  task automatic test_ir_capture_update();
    logic [3:0] cap;
    ir_scan(4'h2, cap);
    n_checks++;
    if (cap !== 4'b0001) begin
      n_fail++;
      $display("FAIL ir_capture_bits: got %b required 0001", cap);
    end
    n_checks++;
    if (ir_value !== 4'h2) begin
      n_fail++;
      $display("FAIL ir_update: got %h required 2", ir_value);
    end
  endtask

  task automatic test_user_write();
    logic [63:0] dout;
    int cs_cnt, uv_cnt;
    logic cs_first, uv_after, en_all;
    user_capture_data = 32'h1357_9BDF;
    dr_scan(32, {32'h0, 32'hDEAD_BEEF}, dout, cs_cnt, uv_cnt, cs_first, uv_after, en_all);
    upd_m = 32'hDEAD_BEEF;
    n_checks++;
    if (user_update_data !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL user_write_data: got %h required deadbeef", user_update_data);
    end
    n_checks++;
    if (uv_after !== 1'b1 || uv_cnt != 1) begin
      n_fail++;
      $display("FAIL user_write_valid: after=%b count=%0d required 1/1", uv_after, uv_cnt);
    end
  endtask

  task automatic test_user_read();
    logic [63:0] dout;
    int cs_cnt, uv_cnt;
    logic cs_first, uv_after, en_all;
    user_capture_data = 32'hA5A5_0F0F;
    dr_scan(32, {32'h0, upd_m}, dout, cs_cnt, uv_cnt, cs_first, uv_after, en_all);
    n_checks++;
    if (dout[31:0] !== 32'hA5A5_0F0F) begin
      n_fail++;
      $display("FAIL user_read_stream: got %h required a5a50f0f", dout[31:0]);
    end
    n_checks++;
    if (cs_first !== 1'b1 || cs_cnt != 1) begin
      n_fail++;
      $display("FAIL user_read_strobe: first=%b count=%0d required 1/1", cs_first, cs_cnt);
    end
  endtask

  task automatic test_bypass();
    logic [3:0] cap;
    logic [63:0] dout;
    int cs_cnt, uv_cnt;
    logic cs_first, uv_after, en_all;
    ir_scan(4'h7, cap);
    dr_scan(4, 64'b1101, dout, cs_cnt, uv_cnt, cs_first, uv_after, en_all);
    n_checks++;
    if (dout[3:0] !== 4'b1010) begin
      n_fail++;
      $display("FAIL bypass_stream: got %b required 1010 (bit0 first)", dout[3:0]);
    end
    n_checks++;
    if (user_update_data !== upd_m || uv_cnt != 0 || cs_cnt != 0) begin
      n_fail++;
      $display("FAIL bypass_side: upd=%h uv=%0d cs=%0d required upd=%h 0 0",
               user_update_data, uv_cnt, cs_cnt, upd_m);
    end
  endtask

  task automatic test_random_scans();
    logic [3:0] op, cap;
    logic [63:0] din, dout, msk;
    logic [95:0] chain;
    int n, cs_cnt, uv_cnt, sel;
    logic cs_first, uv_after, en_all;
    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 3))
        0:       op = 4'h1;
        1:       op = 4'h2;
        2:       op = 4'hF;
        default: op = 4'($urandom);
      endcase
      ir_scan(op, cap);
      n_checks++;
      if (cap !== 4'b0001 || ir_value !== ir_m) begin
        n_fail++;
        $display("FAIL rand_ir[%0d]: cap=%b ir=%h required 0001 ir=%h", it, cap, ir_value, ir_m);
      end
      user_capture_data = $urandom;
      din = {$urandom, $urandom};
      n = $urandom_range(1, 64);
      sel = sel_of(ir_m);
      chain = model_chain(ir_m, user_capture_data, din);
      msk = mask_of(n);
      dr_scan(n, din, dout, cs_cnt, uv_cnt, cs_first, uv_after, en_all);
      if (sel == 2) upd_m = model_final(chain, n);
      n_checks++;
      if ((dout & msk) !== (chain[63:0] & msk) || en_all !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_stream[%0d]: op=%h n=%0d got %h required %h en=%b",
                 it, ir_m, n, dout & msk, chain[63:0] & msk, en_all);
      end
      n_checks++;
      if (user_update_data !== upd_m) begin
        n_fail++;
        $display("FAIL rand_update[%0d]: op=%h n=%0d got %h required %h",
                 it, ir_m, n, user_update_data, upd_m);
      end
      n_checks++;
      if (cs_first !== (sel == 2) || cs_cnt != int'(sel == 2) ||
          uv_after !== (sel == 2) || uv_cnt != int'(sel == 2)) begin
        n_fail++;
        $display("FAIL rand_strobes[%0d]: cs=%b/%0d uv=%b/%0d required %0d each",
                 it, cs_first, cs_cnt, uv_after, uv_cnt, int'(sel == 2));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] cap;
    logic [63:0] dout, din;
    logic [95:0] chain;
    int cs_cnt, uv_cnt;
    logic cs_first, uv_after, en_all;
    ir_scan(4'h2, cap);
    for (int k = 0; k < 3; k++) begin
      user_capture_data = $urandom;
      din = {32'h0, $urandom};
      chain = model_chain(ir_m, user_capture_data, din);
      dr_scan(1, din, dout, cs_cnt, uv_cnt, cs_first, uv_after, en_all);
      upd_m = model_final(chain, 1);
      n_checks++;
      if (user_update_data !== upd_m || uv_after !== 1'b1 || uv_cnt != 1) begin
        n_fail++;
        $display("FAIL b2b[%0d]: upd=%h uv=%b/%0d required upd=%h uv=1/1",
                 k, user_update_data, uv_after, uv_cnt, upd_m);
      end
    end
  endtask

  task automatic test_tlr_mid_scan();
    logic [3:0] cap;
    int uv_seen;
    ir_scan(4'h2, cap);
    user_capture_data = $urandom;
    cycle(S_CDR, 1'b0);
    for (int i = 0; i < 5; i++) cycle(S_SDR, 1'($urandom));
    cycle(S_TLR | S_UDR, 1'b0);
    uv_seen = int'(obs_uv);
    cycle(S_UDR, 1'b0);
    uv_seen += int'(obs_uv);
    cycle(S_NONE, 1'b0);
    uv_seen += int'(obs_uv);
    ir_m = 4'h1;
    n_checks++;
    if (ir_value !== 4'h1) begin
      n_fail++;
      $display("FAIL tlr_ir: got %h required 1", ir_value);
    end
    n_checks++;
    if (uv_seen != 0 || user_update_data !== upd_m) begin
      n_fail++;
      $display("FAIL tlr_no_update: uv=%0d upd=%h required 0 upd=%h", uv_seen, user_update_data, upd_m);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [3:0] cap;
    logic [63:0] dout;
    int cs_cnt, uv_cnt;
    logic cs_first, uv_after, en_all;
    ir_scan(4'h2, cap);
    dr_scan(32, {32'h0, 32'h1234_5679}, dout, cs_cnt, uv_cnt, cs_first, uv_after, en_all);
    user_capture_data = 32'hFFFF_FFFF;
    cycle(S_CDR, 1'b0);
    cycle(S_SDR, 1'b1);
    cycle(S_SDR, 1'b1);
    n_checks++;
    if (obs_tdo !== 1'b1 || obs_en !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_shift: tdo=%b en=%b required 1 1", obs_tdo, obs_en);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({tdo, tdo_en, user_capture_strobe, user_update_valid} !== 4'b0000 ||
        user_update_data !== 32'h0 || ir_value !== 4'h1) begin
      n_fail++;
      $display("FAIL async_reset: tdo/en/cs/uv=%b upd=%h ir=%h required 0000 0 1",
               {tdo, tdo_en, user_capture_strobe, user_update_valid}, user_update_data, ir_value);
    end
    @(negedge tck);
    strb = S_NONE;
    reset = 1'b0;
    ir_m = 4'h1; upd_m = 32'h0;
    cycle(S_NONE, 1'b0);
    cycle(S_CDR, 1'b0);
    cycle(S_SDR, 1'b0);
    n_checks++;
    if (obs_tdo !== IDCODE[0] || ir_value !== 4'h1) begin
      n_fail++;
      $display("FAIL post_reset_idcode: tdo=%b ir=%h required 1 1", obs_tdo, ir_value);
    end
    cycle(S_NONE, 1'b0);
  endtask

  initial begin
    reset = 1'b1; strb = S_NONE; tdi = 1'b0; user_capture_data = 32'h0;
    ir_m = 4'h1; upd_m = 32'h0;
    test_reset();
    test_ir_capture_update();
    test_user_write();
    test_user_read();
    test_bypass();
    test_random_scans();
    test_back_to_back();
    test_tlr_mid_scan();
    test_reset_mid_shift();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
